// File: rtl/i2c_fsm.sv
// i2c_fsm: command-level I2C master bit engine.
// Runs one bus primitive per accepted command (START, RESTART, STOP, RD, WR)
// and holds the bus with SCL low between commands until STOP.
// Optional feature macro: I2C_FSM_CLK_STRETCH_EN (stall at end of Q1 while scl_i=0).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd, cmd_valid      command code (0..4 legal) and its valid strobe
//   cmd_ready           engine can accept a command (IDLE/HOLD)
//   din, nack           write byte / RD ack-vs-nack, latched at acceptance
//   dout, ack           last byte read / last WR acknowledge
//   done, err           completion pulse, error flag alongside done
//   scl_o, sda_o        open-drain drives (1 = release)
//   scl_i, sda_i        line levels from the pads
module i2c_fsm #(
    parameter int unsigned DIV_Q = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] din,
    input  logic       nack,
    output logic [7:0] dout,
    output logic       ack,
    output logic       done,
    output logic       err,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam int unsigned DIV_W = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_Q - 1);

    localparam logic [4:0] CMD_START   = 5'd0;
    localparam logic [4:0] CMD_RESTART = 5'd1;
    localparam logic [4:0] CMD_STOP    = 5'd2;
    localparam logic [4:0] CMD_RD      = 5'd3;
    localparam logic [4:0] CMD_WR      = 5'd4;

    typedef enum logic [2:0] {
        IDLE, BUSY_START, BUSY_RESTART, BUSY_STOP, BUSY_WR, BUSY_RD, HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             smp_q, smp_d;
    logic             nack_q, nack_d;
    logic             errp_q, errp_d;
    logic             scl_d, sda_d, ready_d, done_d, err_d, ack_d;
    logic [7:0]       dout_d;
    logic             last_div, stall;

    // SCL/SDA levels for a given step of a primitive: {scl, sda}.
    function automatic logic [1:0] wave(input state_t st, input logic [1:0] qt,
                                        input logic [3:0] bn, input logic txb,
                                        input logic nk);
        logic [1:0] w;
        logic       hi;
        w  = 2'b11;
        hi = (qt == 2'd1) || (qt == 2'd2);
        case (st)
            BUSY_START:   w = (qt == 2'd3) ? 2'b00 : (qt == 2'd2) ? 2'b10 : 2'b11;
            BUSY_RESTART: w = (qt == 2'd0) ? 2'b01 : (qt == 2'd1) ? 2'b11 :
                              (qt == 2'd2) ? 2'b10 : 2'b00;
            BUSY_STOP:    w = (qt == 2'd0) ? 2'b00 : (qt == 2'd1) ? 2'b10 : 2'b11;
            BUSY_WR:      w = {hi, (bn == 4'd8) ? 1'b1 : txb};
            BUSY_RD:      w = {hi, (bn == 4'd8) ? nk : 1'b1};
            default:      w = 2'b11;
        endcase
        return w;
    endfunction

`ifdef I2C_FSM_CLK_STRETCH_EN
    // Slave holding SCL low at the end of Q1 stretches the high phase.
    assign stall = (qtr_q == 2'd1) && last_div && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign last_div = (div_q == DIV_LAST);

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        smp_d   = smp_q;
        nack_d  = nack_q;
        errp_d  = 1'b0;
        scl_d   = scl_o;
        sda_d   = sda_o;
        ready_d = cmd_ready;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ack_d   = ack;
        dout_d  = dout;

        case (state_q)
            IDLE, HOLD: begin
                if (errp_q) begin
                    // Rejected command completes one clock after acceptance.
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                end else if (cmd_valid && cmd_ready) begin
                    div_d   = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 4'd0;
                    shreg_d = din;
                    nack_d  = nack;
                    ready_d = 1'b0;
                    case (cmd)
                        CMD_START, CMD_RESTART:
                            state_d = (state_q == IDLE) ? BUSY_START : BUSY_RESTART;
                        CMD_STOP: if (state_q == HOLD) state_d = BUSY_STOP; else errp_d = 1'b1;
                        CMD_RD:   if (state_q == HOLD) state_d = BUSY_RD;   else errp_d = 1'b1;
                        CMD_WR:   if (state_q == HOLD) state_d = BUSY_WR;   else errp_d = 1'b1;
                        default:  errp_d = 1'b1;
                    endcase
                end
            end
            default: begin
                if (!stall) begin
                    if (qtr_q == 2'd2 && last_div) smp_d = sda_i;
                    if (!last_div) begin
                        div_d = DIV_W'(div_q + DIV_W'(1));
                    end else begin
                        div_d = '0;
                        qtr_d = qtr_q + 2'd1;
                        if (qtr_q == 2'd3) begin
                            if ((state_q == BUSY_WR || state_q == BUSY_RD) && bit_q != 4'd8) begin
                                // Shared shifter: MSB drives WR data, LSB collects RD samples.
                                bit_d   = bit_q + 4'd1;
                                shreg_d = {shreg_q[6:0], smp_q};
                            end else begin
                                done_d  = 1'b1;
                                ready_d = 1'b1;
                                state_d = (state_q == BUSY_STOP) ? IDLE : HOLD;
                                if (state_q == BUSY_RD) dout_d = shreg_q;
                                if (state_q == BUSY_WR) ack_d  = ~smp_q;
                            end
                        end
                    end
                end
            end
        endcase

        // Outputs follow the waveform only while a primitive runs; otherwise they hold.
        if (state_d != IDLE && state_d != HOLD)
            {scl_d, sda_d} = wave(state_d, qtr_d, bit_d, shreg_d[7], nack_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 4'd0;
            shreg_q   <= 8'h00;
            smp_q     <= 1'b1;
            nack_q    <= 1'b0;
            errp_q    <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            ack       <= 1'b0;
            dout      <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            smp_q     <= smp_d;
            nack_q    <= nack_d;
            errp_q    <= errp_d;
            scl_o     <= scl_d;
            sda_o     <= sda_d;
            cmd_ready <= ready_d;
            done      <= done_d;
            err       <= err_d;
            ack       <= ack_d;
            dout      <= dout_d;
        end
    end
endmodule

// File: tb/tb_i2c_fsm.sv
// tb_i2c_fsm: directed self-checking bench for i2c_fsm with DIV_Q=4.
module tb_i2c_fsm;
    localparam int unsigned DIV_Q = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] din;
    logic       nack;
    logic [7:0] dout;
    logic       ack;
    logic       done;
    logic       err;
    logic       scl_o, sda_o, scl_i, sda_i;
    logic       slave_sda;

    // Open-drain bus: slave can only pull SDA low.
    assign scl_i = scl_o;
    assign sda_i = sda_o & slave_sda;

    i2c_fsm #(.DIV_Q(DIV_Q)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .din(din), .nack(nack), .dout(dout), .ack(ack),
        .done(done), .err(err), .scl_o(scl_o), .sda_o(sda_o),
        .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    logic scl_log [0:199];
    logic sda_log [0:199];
    logic rdy0;
    int   done_at;
    logic err_at;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, log the bus per cycle after acceptance until done or budget.
    // sl holds the slave's SDA level per bit slot, bit 0 in sl[8].
    task automatic run(input logic [4:0] c, input logic [7:0] d, input logic n,
                       input logic [8:0] sl, input int budget);
        int k;
        int b;
        @(posedge clk); #1;
        cmd = c; din = d; nack = n; cmd_valid = 1'b1; slave_sda = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 5'd31; din = 8'h00; nack = 1'b0;
        scl_log[0] = scl_o; sda_log[0] = sda_o; rdy0 = cmd_ready;
        slave_sda = sl[8];
        done_at = -1; err_at = 1'b0; k = 0;
        while (done_at < 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
            scl_log[k] = scl_o; sda_log[k] = sda_o;
            if (done) begin
                done_at = k;
                err_at  = err;
            end
            b = k / 16;
            slave_sda = (b <= 8) ? sl[8-b] : 1'b1;
        end
    endtask

    // Recover WR data bits and count SCL shape / SDA-stable-while-SCL-high violations.
    task automatic wr_bits(output logic [7:0] byt, output int viol);
        viol = 0;
        for (int b = 0; b < 8; b++) begin
            byt[7-b] = sda_log[16*b+8];
            for (int k = 16*b; k < 16*b+16; k++) begin
                if (scl_log[k] !== ((k % 16) >= 4 && (k % 16) < 12)) viol++;
                if (scl_log[k] && sda_log[k] !== sda_log[16*b+4]) viol++;
            end
        end
    endtask

    initial begin
        logic [7:0] byt;
        int         viol;
        int         dones;

        reset = 1'b1; cmd = 5'd0; cmd_valid = 1'b0; din = 8'h00; nack = 1'b0; slave_sda = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_scl",   32'(scl_o),     32'd1);
        check("rst_sda",   32'(sda_o),     32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_done",  32'(done),      32'd0);
        check("rst_dout",  32'(dout),      32'h00);
        check("rst_ack",   32'(ack),       32'd0);
        reset = 1'b0;

        // START from IDLE
        run(5'd0, 8'h00, 1'b0, 9'h1FF, 40);
        check("start_busy",     32'(rdy0),       32'd0);
        check("start_sda_pre",  32'(sda_log[7]), 32'd1);
        check("start_sda_fall", 32'(sda_log[8]), 32'd0);
        check("start_scl_hi",   32'(scl_log[11]), 32'd1);
        check("start_scl_lo",   32'(scl_log[12]), 32'd0);
        check("start_done_at",  32'(done_at),    32'd16);
        check("start_err",      32'(err_at),     32'd0);
        check("start_ready",    32'(cmd_ready),  32'd1);
        @(posedge clk); #1;
        check("start_pulse",    32'(done),       32'd0);
        check("hold_scl",       32'(scl_o),      32'd0);

        // WR 0xA5, slave ACKs
        run(5'd4, 8'hA5, 1'b0, 9'h1FE, 160);
        wr_bits(byt, viol);
        check("wr_byte",    32'(byt),     32'hA5);
        check("wr_viol",    32'(viol),    32'd0);
        check("wr_sda_rel", 32'(sda_log[16*8+8]), 32'd1);
        check("wr_done_at", 32'(done_at), 32'd144);
        check("wr_err",     32'(err_at),  32'd0);
        check("wr_ack",     32'(ack),     32'd1);

        // WR 0xA5, slave NACKs
        run(5'd4, 8'hA5, 1'b0, 9'h1FF, 160);
        check("wr2_done_at", 32'(done_at), 32'd144);
        check("wr2_ack",     32'(ack),     32'd0);
        check("wr_dout_kept", 32'(dout),   32'h00);

        // RD 0x3C with NACK
        run(5'd3, 8'h00, 1'b1, {8'h3C, 1'b1}, 160);
        check("rd_done_at",  32'(done_at),          32'd144);
        check("rd_dout",     32'(dout),             32'h3C);
        check("rd_release",  32'(sda_log[8]),       32'd1);
        check("rd_nack_sda", 32'(sda_log[16*8+8]),  32'd1);
        check("rd_nack_scl", 32'(scl_log[16*8+8]),  32'd1);
        check("rd_ack_kept", 32'(ack),              32'd0);

        // STOP from HOLD
        run(5'd2, 8'h00, 1'b0, 9'h1FF, 40);
        check("stop_sda_pre",  32'(sda_log[7]), 32'd0);
        check("stop_sda_rise", 32'(sda_log[8]), 32'd1);
        check("stop_scl_hi",   32'(scl_log[8]), 32'd1);
        check("stop_done_at",  32'(done_at),    32'd16);
        check("stop_idle_scl", 32'(scl_o),      32'd1);
        check("stop_idle_sda", 32'(sda_o),      32'd1);

        // RD from IDLE is rejected without bus activity
        run(5'd3, 8'h00, 1'b0, 9'h1FF, 10);
        check("rdidle_busy",    32'(rdy0),    32'd0);
        check("rdidle_done_at", 32'(done_at), 32'd1);
        check("rdidle_err",     32'(err_at),  32'd1);
        check("rdidle_bus",     32'({scl_log[0], sda_log[0], scl_log[1], sda_log[1]}), 32'hF);
        check("rdidle_dout",    32'(dout),    32'h3C);

        // Illegal code
        run(5'd9, 8'h00, 1'b0, 9'h1FF, 10);
        check("illegal_done_at", 32'(done_at), 32'd1);
        check("illegal_err",     32'(err_at),  32'd1);

        // Reset in the middle of a WR
        run(5'd0, 8'h00, 1'b0, 9'h1FF, 40);
        @(posedge clk); #1;
        cmd = 5'd4; din = 8'h00; cmd_valid = 1'b1; slave_sda = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        dones = 0;
        for (int k = 1; k < 50; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mid_sda_low", 32'(sda_o), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_scl",   32'(scl_o),     32'd1);
        check("mid_rst_sda",   32'(sda_o),     32'd1);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        for (int k = 0; k < 120; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mid_no_done", 32'(dones), 32'd0);
        run(5'd3, 8'h00, 1'b0, 9'h1FF, 10);
        check("mid_idle_err", 32'(err_at), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
